// File: rtl/cpu_dbg_pkg.sv
// Shared types for the end-of-run state dumper.
// State encoding and beat source codes.
package cpu_dbg_pkg;

   typedef enum logic [2:0] {
      COUNT,
      SCAN_REG,
      SCAN_MEM,
      SCAN_SUM,
      DONE
   } dump_state_t;

   localparam logic [1:0] SEL_REG = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_SUM = 2'b10;

endpackage

// File: rtl/dump_halt_detect.sv
// Halt detector: flags a pc that stays unchanged for HALT_WIN counted cycles.
// halt_o is a combinational pulse in the cycle the window fills.
module dump_halt_detect #(
   parameter int HALT_WIN = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [31:0] pc_i,
   output logic        halt_o
);

   localparam int SW = $clog2(HALT_WIN + 1);
   localparam logic [SW-1:0] HIT = SW'(HALT_WIN - 2);
   localparam logic [SW-1:0] ONE = SW'(1);

   logic [31:0]   pc_q;
   logic          seen_q;
   logic [SW-1:0] stall_q;
   logic          same;

   // The first sample after reset has no history to match against.
   assign same   = seen_q && (pc_i == pc_q);
   assign halt_o = en_i && same && (stall_q == HIT);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q    <= '0;
         seen_q  <= 1'b0;
         stall_q <= '0;
      end else if (en_i) begin
         pc_q    <= pc_i;
         seen_q  <= 1'b1;
         stall_q <= same ? stall_q + ONE : '0;
      end
   end

endmodule

// File: rtl/cpu_state_dumper.sv
// End-of-run dumper: counts cycles, then streams regfile and memory words.
// Define DUMP_CHECKSUM_EN to append an XOR checksum beat after the memory scan.
module cpu_state_dumper
   import cpu_dbg_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int REG_N     = 32,
   parameter int MEM_N     = 32,
   parameter int IDX_W     = 8,
   parameter int END_COUNT = 250,
   parameter int HALT_WIN  = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              run_i,
   input  logic [31:0]       pc_i,
   output logic [IDX_W-1:0]  reg_addr_o,
   input  logic [DATA_W-1:0] reg_data_i,
   output logic [IDX_W-1:0]  mem_addr_o,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic              dump_valid_o,
   input  logic              dump_ready_i,
   output logic [1:0]        dump_sel_o,
   output logic [IDX_W-1:0]  dump_idx_o,
   output logic [DATA_W-1:0] dump_data_o,
   output logic [31:0]       cycle_cnt_o,
   output logic              halt_o,
   output logic              done_o
);

   localparam logic [IDX_W:0] REG_LAST = (IDX_W+1)'(REG_N - 1);
   localparam logic [IDX_W:0] MEM_END  = (IDX_W+1)'(MEM_N);
   localparam logic [IDX_W:0] ONE      = (IDX_W+1)'(1);

   dump_state_t    state;
   logic [IDX_W:0] ix;
   logic [31:0]    cnt_inc;
   logic           halt_hit;
   logic           end_hit;
   logic           load;

   dump_halt_detect #(
      .HALT_WIN (HALT_WIN)
   ) u_halt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (run_i && (state == COUNT)),
      .pc_i   (pc_i),
      .halt_o (halt_hit)
   );

   assign cnt_inc = (cycle_cnt_o == '1) ? cycle_cnt_o
                                        : cycle_cnt_o + 32'd1;
   assign end_hit = run_i && (state == COUNT)
                 && (cnt_inc == 32'(END_COUNT));
   assign load    = !dump_valid_o || dump_ready_i;

   assign reg_addr_o = (state == SCAN_REG) ? ix[IDX_W-1:0] : '0;
   assign mem_addr_o = (state == SCAN_MEM) ? ix[IDX_W-1:0] : '0;

`ifdef DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sum_q <= '0;
      end else if (load && state == SCAN_REG) begin
         sum_q <= sum_q ^ reg_data_i;
      end else if (load && state == SCAN_MEM && ix != MEM_END) begin
         sum_q <= sum_q ^ mem_data_i;
      end
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= COUNT;
         ix           <= '0;
         cycle_cnt_o  <= '0;
         halt_o       <= 1'b0;
         done_o       <= 1'b0;
         dump_valid_o <= 1'b0;
         dump_sel_o   <= '0;
         dump_idx_o   <= '0;
         dump_data_o  <= '0;
      end else begin
         unique case (state)
            COUNT: begin
               if (run_i) begin
                  cycle_cnt_o <= cnt_inc;
                  if (end_hit || halt_hit) begin
                     state  <= SCAN_REG;
                     halt_o <= halt_hit;
                     ix     <= '0;
                  end
               end
            end
            SCAN_REG: begin
               if (load) begin
                  dump_valid_o <= 1'b1;
                  dump_sel_o   <= SEL_REG;
                  dump_idx_o   <= ix[IDX_W-1:0];
                  dump_data_o  <= reg_data_i;
                  if (ix == REG_LAST) begin
                     ix    <= '0;
                     state <= SCAN_MEM;
                  end else begin
                     ix <= ix + ONE;
                  end
               end
            end
            SCAN_MEM: begin
               if (load) begin
                  if (ix != MEM_END) begin
                     dump_valid_o <= 1'b1;
                     dump_sel_o   <= SEL_MEM;
                     dump_idx_o   <= ix[IDX_W-1:0];
                     dump_data_o  <= mem_data_i;
                     ix           <= ix + ONE;
                  end else begin
                     // Last memory beat is being accepted here.
`ifdef DUMP_CHECKSUM_EN
                     dump_sel_o  <= SEL_SUM;
                     dump_idx_o  <= '0;
                     dump_data_o <= sum_q;
                     state       <= SCAN_SUM;
`else
                     dump_valid_o <= 1'b0;
                     done_o       <= 1'b1;
                     state        <= DONE;
`endif
                  end
               end
            end
            SCAN_SUM: begin
               if (dump_ready_i) begin
                  dump_valid_o <= 1'b0;
                  done_o       <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
            end
            default: state <= COUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Scoreboard bench for cpu_state_dumper.
// Honours DUMP_CHECKSUM_EN for the extra checksum beat.
module tb_cpu_state_dumper;
   import cpu_dbg_pkg::*;

`ifdef DUMP_CHECKSUM_EN
   localparam int NB = 65;
`else
   localparam int NB = 64;
`endif

   typedef struct packed {
      logic [1:0]  sel;
      logic [7:0]  idx;
      logic [31:0] data;
   } beat_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        run_i = 1'b0;
   logic [31:0] pc_i = '0;
   logic [7:0]  reg_addr_o;
   logic [31:0] reg_data_i;
   logic [7:0]  mem_addr_o;
   logic [31:0] mem_data_i;
   logic        dump_valid_o;
   logic        dump_ready_i = 1'b0;
   logic [1:0]  dump_sel_o;
   logic [7:0]  dump_idx_o;
   logic [31:0] dump_data_o;
   logic [31:0] cycle_cnt_o;
   logic        halt_o;
   logic        done_o;

   logic [31:0] regs [32];
   logic [31:0] mem  [32];
   beat_t       q [$];
   int          checks = 0;
   int          errors = 0;
   int          nbeats = 0;
   bit          rpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   always #5 clk_i = ~clk_i;

   assign reg_data_i = (reg_addr_o < 8'd32) ? regs[reg_addr_o[4:0]] : '0;
   assign mem_data_i = (mem_addr_o < 8'd32) ? mem[mem_addr_o[4:0]] : '0;

   cpu_state_dumper dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .run_i        (run_i),
      .pc_i         (pc_i),
      .reg_addr_o   (reg_addr_o),
      .reg_data_i   (reg_data_i),
      .mem_addr_o   (mem_addr_o),
      .mem_data_i   (mem_data_i),
      .dump_valid_o (dump_valid_o),
      .dump_ready_i (dump_ready_i),
      .dump_sel_o   (dump_sel_o),
      .dump_idx_o   (dump_idx_o),
      .dump_data_o  (dump_data_o),
      .cycle_cnt_o  (cycle_cnt_o),
      .halt_o       (halt_o),
      .done_o       (done_o)
   );

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic void set_data(input int pat);
      for (int i = 0; i < 32; i++) begin
         if (pat == 0) begin
            regs[i] = 32'(i);
            mem[i]  = 32'h100 + 32'(i);
         end else begin
            regs[i] = 32'hDEAD_0000 ^ (32'(i) * 32'h0101_0101);
            mem[i]  = 32'h5A5A_0000 + 32'(i * i);
         end
      end
   endfunction

   function automatic void push_all();
      beat_t b;
`ifdef DUMP_CHECKSUM_EN
      logic [31:0] x;
      x = '0;
`endif
      for (int i = 0; i < 32; i++) begin
         b.sel  = SEL_REG;
         b.idx  = 8'(i);
         b.data = regs[i];
         q.push_back(b);
`ifdef DUMP_CHECKSUM_EN
         x ^= regs[i];
`endif
      end
      for (int i = 0; i < 32; i++) begin
         b.sel  = SEL_MEM;
         b.idx  = 8'(i);
         b.data = mem[i];
         q.push_back(b);
`ifdef DUMP_CHECKSUM_EN
         x ^= mem[i];
`endif
      end
`ifdef DUMP_CHECKSUM_EN
      b.sel  = SEL_SUM;
      b.idx  = '0;
      b.data = x;
      q.push_back(b);
`endif
   endfunction

   function automatic logic [31:0] pc_for(input int mode, input int k);
      if (mode == 0) return 32'(4 * k);
      if (mode == 1) return (k < 20) ? 32'h1000 + 32'(4 * k) : 32'h40;
      return 32'h80;
   endfunction

   // Monitor: scoreboard pops plus stability under backpressure.
   logic        hold_v = 1'b0;
   logic [42:0] hold_b;
   logic [15:0] hold_a;
   always @(negedge clk_i) begin
      beat_t e;
      if (rst_i) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            check("stall_beat",
                  {dump_valid_o, dump_sel_o, dump_idx_o, dump_data_o}, hold_b);
            check("stall_addr", {reg_addr_o, mem_addr_o}, hold_a);
         end
         if (dump_valid_o && dump_ready_i) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got sel=%0d idx=%0d data=%h, none expected",
                        dump_sel_o, dump_idx_o, dump_data_o);
            end else begin
               e = q.pop_front();
               check("beat", {dump_sel_o, dump_idx_o, dump_data_o}, e);
            end
            nbeats++;
         end
         hold_v = dump_valid_o && !dump_ready_i;
         hold_b = {dump_valid_o, dump_sel_o, dump_idx_o, dump_data_o};
         hold_a = {reg_addr_o, mem_addr_o};
      end
   end

   task automatic do_reset();
      rst_i        = 1'b1;
      run_i        = 1'b0;
      dump_ready_i = 1'b0;
      pc_i         = '0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i  = 1'b0;
      q.delete();
      nbeats = 0;
   endtask

   task automatic run_until_done(input int mode, input bit bp,
                                 input int bound,
                                 output int c0, output int c1);
      int k;
      k  = 0;
      c0 = -1;
      c1 = -1;
      run_i        = 1'b1;
      pc_i         = pc_for(mode, 1);
      dump_ready_i = bp ? rpat[0] : 1'b1;
      while (k < bound) begin
         @(posedge clk_i);
         k++;
         #1;
         pc_i = pc_for(mode, k + 1);
         if (bp) dump_ready_i = rpat[k % 4];
         if (dump_valid_o && c0 < 0) c0 = k;
         if (done_o) begin
            c1 = k;
            break;
         end
      end
      if (c1 < 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done in %0d cycles, expected done", bound);
      end
   endtask

   task automatic check_end(input string tag, input logic [31:0] cnt,
                            input logic halt);
      check({tag, "_cnt"}, cycle_cnt_o, cnt);
      check({tag, "_halt"}, halt_o, halt);
      check({tag, "_done_valid"}, {done_o, dump_valid_o}, 2'b10);
      check({tag, "_beats"}, nbeats, NB);
      check({tag, "_queue"}, q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1;

      // Reset values and counted end.
      set_data(0);
      do_reset();
      check("rst_beat", {dump_valid_o, dump_sel_o, dump_idx_o, dump_data_o}, 0);
      check("rst_misc", {cycle_cnt_o, halt_o, done_o, reg_addr_o, mem_addr_o}, 0);
      push_all();
      run_until_done(0, 1'b0, 600, c0, c1);
      check("t1_first_valid", c0, 251);
      check("t1_no_bubble", c1 - c0, NB);
      check_end("t1", 32'd250, 1'b0);

      // Halt detect, different data, done sticky.
      set_data(1);
      do_reset();
      push_all();
      run_until_done(1, 1'b0, 400, c0, c1);
      repeat (5) @(posedge clk_i);
      #1;
      check_end("t2", 32'd27, 1'b1);

      // Backpressure with ready pattern 1,0,0,1.
      do_reset();
      push_all();
      run_until_done(2, 1'b1, 800, c0, c1);
      check_end("t3", 32'd8, 1'b1);

      // run_i low: no counting, no halt.
      do_reset();
      pc_i = 32'h80;
      repeat (50) @(posedge clk_i);
      #1;
      check("t4_idle", {cycle_cnt_o, halt_o, dump_valid_o, done_o}, 0);
      push_all();
      run_until_done(2, 1'b0, 400, c0, c1);
      check_end("t4", 32'd8, 1'b1);

      // Reset in the middle of the memory scan.
      set_data(0);
      do_reset();
      push_all();
      run_i        = 1'b1;
      pc_i         = 32'h80;
      dump_ready_i = 1'b1;
      for (int k = 0; k < 200 && nbeats != 40; k++) begin
         @(posedge clk_i);
         #1;
      end
      check("t5_beats", nbeats, 40);
      check("t5_in_mem", {dump_valid_o, dump_sel_o, dump_idx_o},
            {1'b1, SEL_MEM, 8'd8});
      dump_ready_i = 1'b0;
      rst_i        = 1'b1;
      @(posedge clk_i);
      #1;
      check("t5_rst", {dump_valid_o, cycle_cnt_o, done_o, halt_o}, 0);
      rst_i = 1'b0;
      q.delete();
      for (int k = 1; k <= 5; k++) begin
         pc_i = pc_for(0, k);
         @(posedge clk_i);
      end
      #1;
      check("t5_recount", {cycle_cnt_o, dump_valid_o}, {32'd5, 1'b0});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
